// File: rtl/data_sync_mc_if.sv
// data_sync_mc_if: per-channel enable/data/handshake bundle for data_sync_mc.
interface data_sync_mc_if #(
   parameter int NUM_CHANNELS = 2,
   parameter int BUS_WIDTH = 8
);
   logic [NUM_CHANNELS-1:0] bus_enable;
   logic [NUM_CHANNELS*BUS_WIDTH-1:0] unsync_bus;
   logic [NUM_CHANNELS-1:0] sync_ack;
   logic [NUM_CHANNELS-1:0] overrun_clr;
   logic [NUM_CHANNELS*BUS_WIDTH-1:0] sync_bus;
   logic [NUM_CHANNELS-1:0] enable_pulse;
   logic [NUM_CHANNELS-1:0] sync_valid;
   logic [NUM_CHANNELS-1:0] overrun;
   modport master (
      output bus_enable, unsync_bus, sync_ack, overrun_clr,
      input sync_bus, enable_pulse, sync_valid, overrun
   );
   modport slave (
      input bus_enable, unsync_bus, sync_ack, overrun_clr,
      output sync_bus, enable_pulse, sync_valid, overrun
   );
endinterface

// File: rtl/data_sync_mc.sv
// data_sync_mc: multi-channel enable-qualified bus synchronizer with valid/ack hold.
// Sticky overrun tracking is built only when DATA_SYNC_OVERRUN_EN is defined.
module data_sync_mc #(
   parameter int NUM_CHANNELS = 2,
   parameter int BUS_WIDTH = 8,
   parameter int NUM_STAGES = 2,
   parameter int EN_MODE = 0
) (
   input logic CLK,
   input logic RST,
   data_sync_mc_if.slave io
);
   if (NUM_STAGES < 2) begin : g_bad_stages
      $error("data_sync_mc: NUM_STAGES must be >= 2");
   end
   logic [NUM_CHANNELS-1:0][NUM_STAGES-1:0] sync_q, sync_d;
   logic [NUM_CHANNELS-1:0][BUS_WIDTH-1:0] bus_q, bus_d;
   logic [NUM_CHANNELS-1:0] en_prev_q, en_prev_d;
   logic [NUM_CHANNELS-1:0] pulse_q, pulse_d;
   logic [NUM_CHANNELS-1:0] valid_q, valid_d;
   logic [NUM_CHANNELS-1:0] ovr_q, ovr_d;
   logic [NUM_CHANNELS-1:0] qual;
   always_comb begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         sync_d[c] = {sync_q[c][NUM_STAGES-2:0], io.bus_enable[c]};
         en_prev_d[c] = sync_q[c][NUM_STAGES-1];
         qual[c] = (EN_MODE == 1) ? (sync_q[c][NUM_STAGES-1] ^ en_prev_q[c])
                                  : (sync_q[c][NUM_STAGES-1] & ~en_prev_q[c]);
         bus_d[c] = qual[c] ? io.unsync_bus[c*BUS_WIDTH +: BUS_WIDTH] : bus_q[c];
         pulse_d[c] = qual[c];
         valid_d[c] = qual[c] | (valid_q[c] & ~io.sync_ack[c]);
`ifdef DATA_SYNC_OVERRUN_EN
         // a capture that lands on unacked data sets the flag; set beats clear
         ovr_d[c] = (qual[c] & valid_q[c] & ~io.sync_ack[c]) | (ovr_q[c] & ~io.overrun_clr[c]);
`else
         ovr_d[c] = 1'b0;
`endif
      end
   end
`ifndef DATA_SYNC_OVERRUN_EN
   logic unused_clr;
   assign unused_clr = ^io.overrun_clr;
`endif
   always_ff @(posedge CLK) begin
      if (!RST) begin
         sync_q <= '0;
         en_prev_q <= '0;
         bus_q <= '0;
         pulse_q <= '0;
         valid_q <= '0;
         ovr_q <= '0;
      end else begin
         sync_q <= sync_d;
         en_prev_q <= en_prev_d;
         bus_q <= bus_d;
         pulse_q <= pulse_d;
         valid_q <= valid_d;
         ovr_q <= ovr_d;
      end
   end
   assign io.sync_bus = bus_q;
   assign io.enable_pulse = pulse_q;
   assign io.sync_valid = valid_q;
   assign io.overrun = ovr_q;
endmodule
